// File: rtl/alu_ctrl_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_sequencer_if
//  Brief    : Handshake and datapath strobe bundle between controller, ALU
//             control-step sequencer and datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_ctrl_sequencer_if #(
  parameter int IR_W = 32
);
  logic            start;
  logic [IR_W-1:0] ir;
  logic            busy;
  logic            done;
  logic            err;
  logic            PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read;
  logic            MDRin, MDRout, IRin;
  logic            Gra, Grb, Grc, Rin, Rout, Yin, Cout, HIin, LOin;
  logic [4:0]      opcode;

  // Sequencer side: consumes start/ir, drives status and strobes.
  modport master (
    input  start, ir,
    output busy, done, err,
    output PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read,
    output MDRin, MDRout, IRin,
    output Gra, Grb, Grc, Rin, Rout, Yin, Cout, HIin, LOin,
    output opcode
  );

  // Controller/datapath side.
  modport slave (
    output start, ir,
    input  busy, done, err,
    input  PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read,
    input  MDRin, MDRout, IRin,
    input  Gra, Grb, Grc, Rin, Rout, Yin, Cout, HIin, LOin,
    input  opcode
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_sequencer
//  Brief    : Control-step sequencer: fetch (T0-T2), decode and execute
//             (T3-T6) of ALU instructions, then a one-cycle done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_sequencer #(
  parameter int HOLD = 1,
  parameter int IR_W = 32
) (
  input  wire logic             clk,
  input  wire logic             clr,
  alu_ctrl_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_HL  = 3'd2,
    CLS_U   = 3'd3,
    CLS_ILL = 3'd4
  } class_t;

  localparam logic [4:0] c_nop      = 5'b00000;
  localparam logic [3:0] c_last_cnt = 4'(HOLD - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_err, w_err_next;
  logic        w_last;
  logic        w_in_t;
  logic [4:0]  w_op;
  class_t      w_cls;
  logic [4:0]  w_alu_op;
  logic        w_unused_ir;

  assign w_op        = bus.ir[IR_W-1 -: 5];
  assign w_unused_ir = ^bus.ir;
  assign w_last      = (r_cnt == c_last_cnt);
  assign w_in_t      = (r_state != S_IDLE) && (r_state != S_DONE);

  // Opcode field -> instruction class and ALU operation
  always_comb begin
    w_cls    = CLS_ILL;
    w_alu_op = c_nop;
    case (w_op)
      5'b00000: begin w_cls = CLS_R;  w_alu_op = 5'b00001; end
      5'b00001: begin w_cls = CLS_R;  w_alu_op = 5'b00010; end
      5'b00010: begin w_cls = CLS_R;  w_alu_op = 5'b01010; end
      5'b00011: begin w_cls = CLS_R;  w_alu_op = 5'b01011; end
      5'b00100: begin w_cls = CLS_R;  w_alu_op = 5'b00101; end
      5'b00101: begin w_cls = CLS_R;  w_alu_op = 5'b00111; end
      5'b00110: begin w_cls = CLS_R;  w_alu_op = 5'b00110; end
      5'b00111: begin w_cls = CLS_R;  w_alu_op = 5'b01000; end
      5'b01000: begin w_cls = CLS_R;  w_alu_op = 5'b01001; end
      5'b01100: begin w_cls = CLS_I;  w_alu_op = 5'b00001; end
      5'b01101: begin w_cls = CLS_I;  w_alu_op = 5'b01010; end
      5'b01110: begin w_cls = CLS_I;  w_alu_op = 5'b01011; end
      5'b01111: begin w_cls = CLS_HL; w_alu_op = 5'b00011; end
      5'b10000: begin w_cls = CLS_HL; w_alu_op = 5'b00100; end
      5'b10001: begin w_cls = CLS_U;  w_alu_op = 5'b01100; end
      5'b10010: begin w_cls = CLS_U;  w_alu_op = 5'b01111; end
      default:  begin w_cls = CLS_ILL; w_alu_op = c_nop; end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  // Next state, hold counter and illegal-opcode flag
  always_comb begin
    w_next     = r_state;
    w_cnt_next = 4'd0;
    w_err_next = r_err;
    if (w_in_t && !w_last)
      w_cnt_next = r_cnt + 4'd1;
    case (r_state)
      S_IDLE: begin
        w_err_next = 1'b0;
        if (bus.start)
          w_next = S_T0;
      end
      S_T0: if (w_last) w_next = S_T1;
      S_T1: if (w_last) w_next = S_T2;
      S_T2: begin
        // The class must be known on the final T2 cycle to skip execution.
        if (w_last) begin
          if (w_cls == CLS_ILL) begin
            w_next     = S_DONE;
            w_err_next = 1'b1;
          end else begin
            w_next     = S_T3;
          end
        end
      end
      S_T3: if (w_last) w_next = S_T4;
      S_T4: if (w_last) w_next = S_T5;
      S_T5: if (w_last) w_next = (w_cls == CLS_HL) ? S_T6 : S_DONE;
      S_T6: if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: begin
        w_next     = S_IDLE;
        w_err_next = 1'b0;
      end
    endcase
  end

  // Strobes: enables only on the final cycle of a state, others for the whole state
  always_comb begin
    bus.busy     = (r_state != S_IDLE);
    bus.done     = (r_state == S_DONE);
    bus.err      = (r_state == S_DONE) && r_err;
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.incPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.ZLowOut  = 1'b0;
    bus.ZHighOut = 1'b0;
    bus.PCin     = 1'b0;
    bus.read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Cout     = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.opcode   = c_nop;
    case (r_state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.incPC = 1'b1;
        bus.MARin = w_last;
        bus.Zin   = w_last;
      end
      S_T1: begin
        bus.ZLowOut = 1'b1;
        bus.read    = 1'b1;
        bus.PCin    = w_last;
        bus.MDRin   = w_last;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = w_last;
      end
      S_T3: begin
        bus.Grb  = 1'b1;
        bus.Rout = 1'b1;
        bus.Yin  = w_last;
      end
      S_T4: begin
        bus.Zin    = w_last;
        bus.opcode = w_alu_op;
        case (w_cls)
          CLS_R, CLS_HL: begin bus.Grc = 1'b1; bus.Rout = 1'b1; end
          CLS_I:         bus.Cout = 1'b1;
          CLS_U:         begin bus.Grb = 1'b1; bus.Rout = 1'b1; end
          default:       bus.opcode = c_nop;
        endcase
      end
      S_T5: begin
        bus.ZLowOut = 1'b1;
        if (w_cls == CLS_HL) begin
          bus.LOin = w_last;
        end else begin
          bus.Gra  = 1'b1;
          bus.Rin  = w_last;
        end
      end
      S_T6: begin
        bus.ZHighOut = 1'b1;
        bus.HIin     = w_last;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_sequencer
//  Brief    : Randomized cycle-by-cycle check of the sequencer at HOLD=1 and
//             HOLD=3 against a step-table reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_sequencer;

  typedef struct packed {
    logic busy, done, err;
    logic PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, read;
    logic MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, Yin, Cout, HIin, LOin;
    logic [4:0] opcode;
  } outs_t;

  localparam int ST_DONE = 7;
  localparam int ST_IDLE = 8;
  localparam int CL_R = 0, CL_I = 1, CL_HL = 2, CL_U = 3, CL_ILL = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_ctrl_sequencer_if #(.IR_W(32)) bus1 ();
  alu_ctrl_sequencer_if #(.IR_W(32)) bus3 ();

  alu_ctrl_sequencer #(.HOLD(1), .IR_W(32)) u_dut1 (.clk(clk), .clr(clr), .bus(bus1));
  alu_ctrl_sequencer #(.HOLD(3), .IR_W(32)) u_dut3 (.clk(clk), .clr(clr), .bus(bus3));

  outs_t obs1, obs3;
  assign obs1 = {bus1.busy, bus1.done, bus1.err, bus1.PCout, bus1.MARin, bus1.incPC, bus1.Zin,
                 bus1.ZLowOut, bus1.ZHighOut, bus1.PCin, bus1.read, bus1.MDRin, bus1.MDRout,
                 bus1.IRin, bus1.Gra, bus1.Grb, bus1.Grc, bus1.Rin, bus1.Rout, bus1.Yin,
                 bus1.Cout, bus1.HIin, bus1.LOin, bus1.opcode};
  assign obs3 = {bus3.busy, bus3.done, bus3.err, bus3.PCout, bus3.MARin, bus3.incPC, bus3.Zin,
                 bus3.ZLowOut, bus3.ZHighOut, bus3.PCin, bus3.read, bus3.MDRin, bus3.MDRout,
                 bus3.IRin, bus3.Gra, bus3.Grb, bus3.Grc, bus3.Rin, bus3.Rout, bus3.Yin,
                 bus3.Cout, bus3.HIin, bus3.LOin, bus3.opcode};

  task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %07h expected %07h", tag, got, exp);
    end
  endtask

  task automatic ref_decode(input logic [4:0] op, output int cls, output logic [4:0] aop);
    cls = CL_ILL;
    aop = 5'b00000;
    case (op)
      5'd0:  begin cls = CL_R;  aop = 5'b00001; end
      5'd1:  begin cls = CL_R;  aop = 5'b00010; end
      5'd2:  begin cls = CL_R;  aop = 5'b01010; end
      5'd3:  begin cls = CL_R;  aop = 5'b01011; end
      5'd4:  begin cls = CL_R;  aop = 5'b00101; end
      5'd5:  begin cls = CL_R;  aop = 5'b00111; end
      5'd6:  begin cls = CL_R;  aop = 5'b00110; end
      5'd7:  begin cls = CL_R;  aop = 5'b01000; end
      5'd8:  begin cls = CL_R;  aop = 5'b01001; end
      5'd12: begin cls = CL_I;  aop = 5'b00001; end
      5'd13: begin cls = CL_I;  aop = 5'b01010; end
      5'd14: begin cls = CL_I;  aop = 5'b01011; end
      5'd15: begin cls = CL_HL; aop = 5'b00011; end
      5'd16: begin cls = CL_HL; aop = 5'b00100; end
      5'd17: begin cls = CL_U;  aop = 5'b01100; end
      5'd18: begin cls = CL_U;  aop = 5'b01111; end
      default: ;
    endcase
  endtask

  // Expected outputs for step st (0..6 = T0..T6) on a given cycle of that step
  function automatic outs_t model_out(int st, bit last, int cls, logic [4:0] aop);
    outs_t o = '0;
    o.busy = (st != ST_IDLE);
    o.done = (st == ST_DONE);
    o.err  = (st == ST_DONE) && (cls == CL_ILL);
    case (st)
      0: begin o.PCout = 1; o.incPC = 1; o.MARin = last; o.Zin = last; end
      1: begin o.ZLowOut = 1; o.read = 1; o.PCin = last; o.MDRin = last; end
      2: begin o.MDRout = 1; o.IRin = last; end
      3: begin o.Grb = 1; o.Rout = 1; o.Yin = last; end
      4: begin
        o.opcode = aop;
        o.Zin    = last;
        if (cls == CL_I) o.Cout = 1;
        else if (cls == CL_U) begin o.Grb = 1; o.Rout = 1; end
        else begin o.Grc = 1; o.Rout = 1; end
      end
      5: begin
        o.ZLowOut = 1;
        if (cls == CL_HL) o.LOin = last;
        else begin o.Gra = 1; o.Rin = last; end
      end
      6: begin o.ZHighOut = 1; o.HIin = last; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic build_expect(input int hold, input logic [31:0] instr, output outs_t q[$]);
    int cls;
    logic [4:0] aop;
    int steps[$];
    q = {};
    ref_decode(instr[31:27], cls, aop);
    steps = {0, 1, 2};
    if (cls != CL_ILL) steps = {steps, 3, 4, 5};
    if (cls == CL_HL) steps.push_back(6);
    foreach (steps[s])
      for (int k = 0; k < hold; k++)
        q.push_back(model_out(steps[s], k == hold - 1, cls, aop));
    q.push_back(model_out(ST_DONE, 1'b0, cls, aop));
    q.push_back(model_out(ST_IDLE, 1'b0, cls, aop));
  endtask

  // One instruction on the chosen DUT; optional stray start pulse while busy
  task automatic run_instr(input int hold, input logic [31:0] instr, input bit stray, input string name);
    outs_t exp_q[$];
    int pulse_at;
    outs_t got;
    build_expect(hold, instr, exp_q);
    pulse_at = stray ? $urandom_range(0, exp_q.size() - 2) : -1;
    @(negedge clk);
    if (hold == 1) begin bus1.ir = instr; bus1.start = 1'b1; end
    else begin bus3.ir = instr; bus3.start = 1'b1; end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      got = (hold == 1) ? obs1 : obs3;
      check_eq($sformatf("%s h%0d ir=%08h cyc%0d", name, hold, instr, i + 1), got, exp_q[i]);
      @(negedge clk);
      if (hold == 1) bus1.start = (i == pulse_at);
      else bus3.start = (i == pulse_at);
    end
  endtask

  initial begin
    logic [31:0] instr;
    outs_t exp_t4;
    int cls;
    logic [4:0] aop;
    bus1.start = 0; bus1.ir = '0;
    bus3.start = 0; bus3.ir = '0;

    #2;
    check_eq("reset_dut1", obs1, '0);
    check_eq("reset_dut3", obs3, '0);
    @(negedge clk);
    clr = 1'b1;

    run_instr(1, 32'h611BFFFD, 1'b0, "addi");
    run_instr(1, {5'b00001, 27'h0123456}, 1'b0, "sub");
    run_instr(1, {5'b01111, 27'h0456789}, 1'b0, "mul");
    run_instr(3, 32'h611BFFFD, 1'b0, "addi");
    run_instr(1, {5'b11111, 27'h0000000}, 1'b0, "illegal");
    run_instr(3, {5'b11111, 27'h7FFFFFF}, 1'b0, "illegal");
    run_instr(3, {5'b10000, 27'h0}, 1'b1, "div_stray");
    run_instr(1, {5'b10010, 27'h0}, 1'b1, "not_stray");

    // Asynchronous clear in the middle of T4
    @(negedge clk);
    bus1.ir = 32'h611BFFFD;
    bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ref_decode(5'b01100, cls, aop);
    exp_t4 = model_out(4, 1'b1, cls, aop);
    check_eq("clr_pre_t4", obs1, exp_t4);
    #3 clr = 1'b0;
    #1;
    check_eq("clr_async_dut1", obs1, '0);
    check_eq("clr_async_dut3", obs3, '0);
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    check_eq("clr_held_start", obs1, '0);
    @(negedge clk);
    bus1.start = 1'b0;
    clr = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("idle_after_clr", obs1, '0);
    end
    run_instr(1, {5'b00011, 27'h1234}, 1'b0, "or_resume");

    for (int n = 0; n < 40; n++) begin
      instr = $urandom;
      run_instr((n % 2 == 0) ? 1 : 3, instr, ($urandom_range(0, 1) == 1), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
